// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the control sequencer: FSM states, instruction fields,
// ALU codes and the packed layout of the Control word.
package control_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_e;

  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Data-processing command field, Funct[4:1]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_MOV = 4'b0100;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] REGSRC_DP  = 2'b00;
  localparam logic [1:0] REGSRC_BR  = 2'b01;
  localparam logic [1:0] REGSRC_STR = 2'b10;

  // Flag bit positions within {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Field order fixes the Control bit positions, MSB (bit 12) first
  typedef struct packed {
    logic       pcsrc;        // [12]
    logic       mem_to_reg;   // [11]
    logic       mem_write;    // [10]
    logic [3:0] alu_control;  // [9:6]
    logic       alu_src;      // [5]
    logic [1:0] imm_src;      // [4:3]
    logic       reg_write;    // [2]
    logic [1:0] reg_src;      // [1:0]
  } ctrl_t;

  localparam int CTL_W = $bits(ctrl_t);

endpackage

// File: rtl/cond_check.sv
// Evaluates an instruction condition code against the registered {N,Z,C,V}.
module cond_check
  import control_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Run/step/halt sequencer with a combinational instruction decoder, condition
// flags register and retired-instruction counter.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             stop,
  input  logic [19:0]      InstrControl,
  input  logic [3:0]       ALUFlags,
  output logic [CTL_W-1:0] Control,
  output logic             PCWrite,
  output logic             Running,
  output logic             Halted,
  output logic [3:0]       Flags,
  output logic [15:0]      InstrCount
);

  state_e      state_q, state_d;
  logic [3:0]  flags_q, flags_d;
  logic [15:0] count_q, count_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       unused_instr_low;

  assign cond  = InstrControl[19:16];
  assign op    = InstrControl[15:14];
  assign funct = InstrControl[13:8];
  assign cmd   = funct[4:1];
  assign rd    = InstrControl[7:4];
  assign unused_instr_low = ^InstrControl[3:0];

  logic  cond_ex;
  logic  exec;
  logic  flag_load;
  ctrl_t dec;

  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  // Decode is purely combinational; it is gated to zero outside exec cycles
  always_comb begin
    dec = '0;
    case (op)
      OP_DP: begin
        dec.alu_src   = funct[5];
        dec.imm_src   = IMM_DP;
        dec.reg_src   = REGSRC_DP;
        dec.reg_write = 1'b1;
        case (cmd)
          CMD_ADD: dec.alu_control = ALU_ADD;
          CMD_SUB: dec.alu_control = ALU_SUB;
          CMD_AND: dec.alu_control = ALU_AND;
          CMD_ORR: dec.alu_control = ALU_ORR;
          CMD_MOV: dec.alu_control = ALU_MOV;
          CMD_CMP: begin
            dec.alu_control = ALU_SUB;
            dec.reg_write   = 1'b0;
          end
          default: begin
            dec.alu_control = ALU_ADD;
            dec.reg_write   = 1'b0;
          end
        endcase
      end
      OP_MEM: begin
        dec.alu_control = ALU_ADD;
        dec.alu_src     = 1'b1;
        dec.imm_src     = IMM_MEM;
        if (funct[0]) begin
          dec.reg_write  = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.reg_src    = REGSRC_DP;
        end else begin
          dec.mem_write = 1'b1;
          dec.reg_src   = REGSRC_STR;
        end
      end
      OP_BR: begin
        dec.pcsrc       = 1'b1;
        dec.alu_src     = 1'b1;
        dec.imm_src     = IMM_BR;
        dec.reg_src     = REGSRC_BR;
        dec.alu_control = ALU_ADD;
      end
      default: ;
    endcase

    // Writing R15 is an indirect jump
    if (dec.reg_write && rd == 4'hF) begin
      dec.pcsrc = 1'b1;
    end

    if (!cond_ex) begin
      dec.pcsrc     = 1'b0;
      dec.mem_write = 1'b0;
      dec.reg_write = 1'b0;
    end
  end

  assign flag_load = cond_ex && (op == OP_DP) && (funct[0] || cmd == CMD_CMP);
  assign exec      = ((state_q == ST_RUN) || (state_q == ST_STEP)) && (op != OP_HALT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
        end else if (step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (stop || op == OP_HALT) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: state_d = (op == OP_HALT) ? ST_HALT : ST_IDLE;
      ST_HALT: begin
        if (start && !stop) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    flags_d = (exec && flag_load) ? ALUFlags : flags_q;
    count_d = exec ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      flags_q <= 4'b0000;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      count_q <= count_d;
    end
  end

  assign Control    = exec ? dec : '0;
  assign PCWrite    = exec;
  assign Running    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign Halted     = (state_q == ST_HALT);
  assign Flags      = flags_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expectations are queued as
// stimulus is driven and compared against the outputs at the falling edge.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, step, stop;
  logic [19:0] InstrControl;
  logic [3:0]  ALUFlags;
  logic [12:0] Control;
  logic        PCWrite, Running, Halted;
  logic [3:0]  Flags;
  logic [15:0] InstrCount;

  control_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .step         (step),
    .stop         (stop),
    .InstrControl (InstrControl),
    .ALUFlags     (ALUFlags),
    .Control      (Control),
    .PCWrite      (PCWrite),
    .Running      (Running),
    .Halted       (Halted),
    .Flags        (Flags),
    .InstrCount   (InstrCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] ctrl;
    logic        pcw;
    logic        run;
    logic        halt;
    logic [3:0]  flags;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } sb_t;

  typedef struct {
    logic        st, sp, so;
    logic [19:0] ins;
    logic [3:0]  alf;
    obs_t        exp;
    string       tag;
  } step_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  logic [15:0] exp_cnt   = 16'h0;
  logic [3:0]  exp_flags = 4'h0;

  function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] o,
                                     input logic [5:0] f, input logic [3:0] r);
    return {c, o, f, r, 4'h0};
  endfunction

  function automatic logic [12:0] ctl(input logic pcsrc, input logic m2r, input logic mw,
                                      input logic [3:0] alu, input logic asrc,
                                      input logic [1:0] imm, input logic rw,
                                      input logic [1:0] rs);
    return {pcsrc, m2r, mw, alu, asrc, imm, rw, rs};
  endfunction

  function automatic obs_t expv(input logic [12:0] c, input logic pcw, input logic run,
                                input logic halt, input logic [3:0] fl, input logic [15:0] cnt);
    obs_t o;
    o.ctrl = c; o.pcw = pcw; o.run = run; o.halt = halt; o.flags = fl; o.cnt = cnt;
    return o;
  endfunction

  function automatic step_t mkstep(input logic st, input logic sp, input logic so,
                                   input logic [19:0] ins, input logic [3:0] alf,
                                   input obs_t exp, input string tag);
    step_t s;
    s.st = st; s.sp = sp; s.so = so; s.ins = ins; s.alf = alf; s.exp = exp; s.tag = tag;
    return s;
  endfunction

  // Instruction encodings: {Cond, Op, Funct, Rd}
  logic [19:0] I_ADD, I_ADDS, I_UNDS, I_CMP, I_CMPNE, I_BEQ, I_BNE, I_LDR, I_STR;
  logic [19:0] I_HALT, I_MOVPC, I_MOVNV;
  logic [12:0] C_ADD, C_CMP, C_BEQ, C_BNE, C_LDR, C_MOVPC, C_MOVNV;
  obs_t        ZERO;

  initial begin
    I_ADD   = mk(4'hE, 2'b00, 6'b001000, 4'h2);
    I_ADDS  = mk(4'hE, 2'b00, 6'b001001, 4'h2);
    I_UNDS  = mk(4'hE, 2'b00, 6'b000011, 4'h2);
    I_CMP   = mk(4'hE, 2'b00, 6'b010101, 4'h0);
    I_CMPNE = mk(4'h1, 2'b00, 6'b010101, 4'h0);
    I_BEQ   = mk(4'h0, 2'b10, 6'b000000, 4'h0);
    I_BNE   = mk(4'h1, 2'b10, 6'b000000, 4'h0);
    I_LDR   = mk(4'hE, 2'b01, 6'b011001, 4'h3);
    I_STR   = mk(4'hE, 2'b01, 6'b011000, 4'h3);
    I_HALT  = mk(4'hE, 2'b11, 6'b000000, 4'h0);
    I_MOVPC = mk(4'hE, 2'b00, 6'b011010, 4'hF);
    I_MOVNV = mk(4'hF, 2'b00, 6'b011010, 4'hF);
    C_ADD   = ctl(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b1, 2'b00);
    C_CMP   = ctl(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'b00, 1'b0, 2'b00);
    C_BEQ   = ctl(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'b10, 1'b0, 2'b01);
    C_BNE   = ctl(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'b10, 1'b0, 2'b01);
    C_LDR   = ctl(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'b01, 1'b1, 2'b00);
    C_MOVPC = ctl(1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 2'b00, 1'b1, 2'b00);
    C_MOVNV = ctl(1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 2'b00, 1'b0, 2'b00);
    ZERO    = expv(13'h0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
  end

  task automatic apply(input logic st, input logic sp, input logic so,
                       input logic [19:0] ins, input logic [3:0] alf);
    @(posedge clk);
    #1;
    start = st; step = sp; stop = so; InstrControl = ins; ALUFlags = alf;
  endtask

  task automatic test_reset();
    sb_t  ent, e;
    obs_t obs;
    rst = 1'b0; start = 1'b1;
    repeat (2) @(posedge clk);
    ent.tag = "reset_state"; ent.v = ZERO;
    sb.push_back(ent);
    @(negedge clk);
    e = sb.pop_front();
    obs = {Control, PCWrite, Running, Halted, Flags, InstrCount};
    n_checks++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end else $display("ok   %s obs=%h", e.tag, obs);
  endtask

  task automatic test_run_add();
    step_t tbl[$];
    sb_t   ent, e;
    obs_t  obs;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; InstrControl = I_ADD;
    tbl.push_back(mkstep(1'b1, 1'b0, 1'b0, I_ADD, 4'h0, ZERO, "idle_start"));
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mkstep(1'b0, 1'b0, 1'b0, I_ADD, 4'($urandom_range(15)),
                           expv(C_ADD, 1'b1, 1'b1, 1'b0, exp_flags, exp_cnt), "run_add"));
      exp_cnt++;
    end
    foreach (tbl[i]) begin
      apply(tbl[i].st, tbl[i].sp, tbl[i].so, tbl[i].ins, tbl[i].alf);
      ent.tag = tbl[i].tag; ent.v = tbl[i].exp;
      sb.push_back(ent);
      @(negedge clk);
      e = sb.pop_front();
      obs = {Control, PCWrite, Running, Halted, Flags, InstrCount};
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
      end else $display("ok   %s obs=%h", e.tag, obs);
    end
  endtask

  task automatic test_cmp_branch();
    step_t tbl[$];
    sb_t   ent, e;
    obs_t  obs;
    tbl.push_back(mkstep(0, 0, 0, I_CMP, 4'b0100, expv(C_CMP, 1, 1, 0, exp_flags, exp_cnt), "cmp_al"));
    exp_cnt++; exp_flags = 4'b0100;
    tbl.push_back(mkstep(0, 0, 0, I_BEQ, 4'b1011, expv(C_BEQ, 1, 1, 0, exp_flags, exp_cnt), "beq_taken"));
    exp_cnt++;
    tbl.push_back(mkstep(0, 0, 0, I_BNE, 4'b0000, expv(C_BNE, 1, 1, 0, exp_flags, exp_cnt), "bne_not_taken"));
    exp_cnt++;
    tbl.push_back(mkstep(0, 0, 0, I_CMPNE, 4'b1000, expv(C_CMP, 1, 1, 0, exp_flags, exp_cnt), "cmpne_skipped"));
    exp_cnt++;
    tbl.push_back(mkstep(0, 0, 0, I_ADDS, 4'b0011, expv(C_ADD, 1, 1, 0, exp_flags, exp_cnt), "adds_al"));
    exp_cnt++; exp_flags = 4'b0011;
    tbl.push_back(mkstep(0, 0, 0, I_UNDS, 4'b0110, expv(13'h0, 1, 1, 0, exp_flags, exp_cnt), "undef_cmd_s"));
    exp_cnt++; exp_flags = 4'b0110;
    tbl.push_back(mkstep(0, 0, 0, I_ADD, 4'b1000, expv(C_ADD, 1, 1, 0, exp_flags, exp_cnt), "add_no_s"));
    exp_cnt++;
    foreach (tbl[i]) begin
      apply(tbl[i].st, tbl[i].sp, tbl[i].so, tbl[i].ins, tbl[i].alf);
      ent.tag = tbl[i].tag; ent.v = tbl[i].exp;
      sb.push_back(ent);
      @(negedge clk);
      e = sb.pop_front();
      obs = {Control, PCWrite, Running, Halted, Flags, InstrCount};
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
      end else $display("ok   %s obs=%h", e.tag, obs);
    end
  endtask

  task automatic test_halt();
    step_t tbl[$];
    sb_t   ent, e;
    obs_t  obs;
    tbl.push_back(mkstep(0, 0, 1, I_HALT, 4'h0, expv(13'h0, 0, 1, 0, exp_flags, exp_cnt), "halt_and_stop"));
    tbl.push_back(mkstep(0, 1, 0, I_ADD, 4'h0, expv(13'h0, 0, 0, 1, exp_flags, exp_cnt), "halt_ignores_step"));
    tbl.push_back(mkstep(1, 0, 1, I_ADD, 4'h0, expv(13'h0, 0, 0, 1, exp_flags, exp_cnt), "halt_start_with_stop"));
    tbl.push_back(mkstep(1, 0, 0, I_ADD, 4'h0, expv(13'h0, 0, 0, 1, exp_flags, exp_cnt), "halt_start"));
    tbl.push_back(mkstep(0, 0, 0, I_ADD, 4'h0, expv(C_ADD, 1, 1, 0, exp_flags, exp_cnt), "rerun_add"));
    exp_cnt++;
    tbl.push_back(mkstep(0, 0, 0, I_HALT, 4'h0, expv(13'h0, 0, 1, 0, exp_flags, exp_cnt), "halt_instr"));
    tbl.push_back(mkstep(0, 0, 0, I_ADD, 4'h0, expv(13'h0, 0, 0, 1, exp_flags, exp_cnt), "halted_again"));
    foreach (tbl[i]) begin
      apply(tbl[i].st, tbl[i].sp, tbl[i].so, tbl[i].ins, tbl[i].alf);
      ent.tag = tbl[i].tag; ent.v = tbl[i].exp;
      sb.push_back(ent);
      @(negedge clk);
      e = sb.pop_front();
      obs = {Control, PCWrite, Running, Halted, Flags, InstrCount};
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
      end else $display("ok   %s obs=%h", e.tag, obs);
    end
  endtask

  task automatic test_step();
    step_t tbl[$];
    sb_t   ent, e;
    obs_t  obs;
    // Reset asserted from HALT; the first row is observed while rst is still low
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 16'h0; exp_flags = 4'h0;
    ent.tag = "reset_from_halt"; ent.v = ZERO;
    sb.push_back(ent);
    @(negedge clk);
    e = sb.pop_front();
    obs = {Control, PCWrite, Running, Halted, Flags, InstrCount};
    n_checks++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end else $display("ok   %s obs=%h", e.tag, obs);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; step = 1'b0; stop = 1'b0;
    tbl.push_back(mkstep(0, 1, 0, I_LDR, 4'h0, ZERO, "idle_step_pulse"));
    tbl.push_back(mkstep(0, 0, 0, I_LDR, 4'h0, expv(C_LDR, 1, 1, 0, 4'h0, 16'h0), "step_ldr"));
    tbl.push_back(mkstep(0, 0, 0, I_STR, 4'h0, expv(13'h0, 0, 0, 0, 4'h0, 16'h1), "str_not_run"));
    tbl.push_back(mkstep(1, 0, 1, I_STR, 4'h0, expv(13'h0, 0, 0, 0, 4'h0, 16'h1), "idle_stop_wins"));
    tbl.push_back(mkstep(0, 0, 0, I_STR, 4'h0, expv(13'h0, 0, 0, 0, 4'h0, 16'h1), "still_idle"));
    exp_cnt = 16'h1;
    foreach (tbl[i]) begin
      apply(tbl[i].st, tbl[i].sp, tbl[i].so, tbl[i].ins, tbl[i].alf);
      ent.tag = tbl[i].tag; ent.v = tbl[i].exp;
      sb.push_back(ent);
      @(negedge clk);
      e = sb.pop_front();
      obs = {Control, PCWrite, Running, Halted, Flags, InstrCount};
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
      end else $display("ok   %s obs=%h", e.tag, obs);
    end
  endtask

  task automatic test_mov_pc();
    step_t tbl[$];
    sb_t   ent, e;
    obs_t  obs;
    tbl.push_back(mkstep(0, 1, 0, I_MOVPC, 4'h0, expv(13'h0, 0, 0, 0, exp_flags, exp_cnt), "idle_step_mov"));
    tbl.push_back(mkstep(0, 0, 0, I_MOVPC, 4'h0, expv(C_MOVPC, 1, 1, 0, exp_flags, exp_cnt), "mov_pc_al"));
    exp_cnt++;
    tbl.push_back(mkstep(0, 1, 0, I_MOVNV, 4'h0, expv(13'h0, 0, 0, 0, exp_flags, exp_cnt), "idle_step_movnv"));
    tbl.push_back(mkstep(0, 0, 0, I_MOVNV, 4'h0, expv(C_MOVNV, 1, 1, 0, exp_flags, exp_cnt), "mov_pc_nv"));
    exp_cnt++;
    tbl.push_back(mkstep(0, 1, 0, I_HALT, 4'h0, expv(13'h0, 0, 0, 0, exp_flags, exp_cnt), "idle_step_halt"));
    tbl.push_back(mkstep(0, 0, 0, I_HALT, 4'h0, expv(13'h0, 0, 1, 0, exp_flags, exp_cnt), "step_halt_instr"));
    tbl.push_back(mkstep(0, 0, 0, I_ADD, 4'h0, expv(13'h0, 0, 0, 1, exp_flags, exp_cnt), "step_to_halt"));
    foreach (tbl[i]) begin
      apply(tbl[i].st, tbl[i].sp, tbl[i].so, tbl[i].ins, tbl[i].alf);
      ent.tag = tbl[i].tag; ent.v = tbl[i].exp;
      sb.push_back(ent);
      @(negedge clk);
      e = sb.pop_front();
      obs = {Control, PCWrite, Running, Halted, Flags, InstrCount};
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
      end else $display("ok   %s obs=%h", e.tag, obs);
    end
  endtask

  task automatic test_wrap();
    sb_t  ent, e;
    obs_t obs;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; step = 1'b0; stop = 1'b0; InstrControl = I_ADD; ALUFlags = 4'h0;
    @(posedge clk); #1;
    start = 1'b0;
    // RUN entered; after 65535 more edges the counter holds 0xFFFF
    repeat (65535) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) @(posedge clk);
      ent.tag = (k == 0) ? "count_ffff" : "count_wrap";
      ent.v   = expv(C_ADD, 1, 1, 0, 4'h0, (k == 0) ? 16'hFFFF : 16'h0000);
      sb.push_back(ent);
      @(negedge clk);
      e = sb.pop_front();
      obs = {Control, PCWrite, Running, Halted, Flags, InstrCount};
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
      end else $display("ok   %s obs=%h", e.tag, obs);
    end
    exp_cnt = 16'h1; exp_flags = 4'h0;
  endtask

  task automatic test_async_reset();
    sb_t  ent, e;
    obs_t obs;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin
          apply(1'b0, 1'b0, 1'b0, I_CMP, 4'b1001);
          ent.tag = "cmp_before_reset";
          ent.v   = expv(C_CMP, 1, 1, 0, exp_flags, exp_cnt);
          sb.push_back(ent);
          @(negedge clk);
        end
        1: begin
          @(posedge clk); #2;
          rst = 1'b0;
          #1;
          ent.tag = "async_reset_immediate"; ent.v = ZERO;
          sb.push_back(ent);
        end
        default: begin
          ent.tag = "reset_held"; ent.v = ZERO;
          sb.push_back(ent);
          @(negedge clk);
        end
      endcase
      e = sb.pop_front();
      obs = {Control, PCWrite, Running, Halted, Flags, InstrCount};
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
      end else $display("ok   %s obs=%h", e.tag, obs);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; step = 1'b0; stop = 1'b0;
    InstrControl = '0; ALUFlags = '0;
    #1;
    test_reset();
    test_run_add();
    test_cmp_branch();
    test_halt();
    test_step();
    test_mov_pc();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
